// File: rtl/vga_axis_pkg.sv
// -----------------------------------------------------------------------------
// vga_axis_pkg
// Shared definitions for the DE/VSYNC -> AXI4-Stream video bridge.
//   state_t        : capture FSM states
//   entry_flags_t  : side-band bits stored ahead of the pixel in each FIFO entry;
//                    a FIFO entry is {entry_flags_t, pixel}
//   clog2()        : constant ceil(log2) used to size pointers and counters
// -----------------------------------------------------------------------------
package vga_axis_pkg;

   typedef enum logic [1:0] {
      SYNC,    // waiting for the first vertical blanking after reset
      ARM,     // in blanking; next active pixel starts a frame
      ACTIVE,  // forwarding pixels
      DROP     // FIFO overflowed; rest of frame discarded
   } state_t;

   typedef struct packed {
      logic sof;   // first pixel of frame  -> TUSER
      logic last;  // last pixel of line    -> TLAST
   } entry_flags_t;

   localparam int ENTRY_FLAG_W = $bits(entry_flags_t);

   function automatic int clog2(input int value);
      int width;
      width = 0;
      while ((1 << width) < value) width++;
      return width;
   endfunction

endpackage

// File: rtl/vga2axis_stream_if.sv
// -----------------------------------------------------------------------------
// vga2axis_stream_if
// AXI4-Stream video bus carried out of the bridge.
//   TDATA  : pixel            TVALID : beat valid        TREADY : sink ready
//   TUSER  : start of frame   TLAST  : end of line       TSTRB  : byte strobe
// Modports: master (bridge side), slave (sink side).
// -----------------------------------------------------------------------------
interface vga2axis_stream_if #(
   parameter int DATA_W = 8
) ();

   logic [DATA_W-1:0] TDATA;
   logic              TVALID;
   logic              TREADY;
   logic              TUSER;
   logic              TLAST;
   logic              TSTRB;

   modport master (output TDATA, TVALID, TUSER, TLAST, TSTRB, input TREADY);
   modport slave  (input TDATA, TVALID, TUSER, TLAST, TSTRB, output TREADY);

endinterface

// File: rtl/axis_sync_fifo.sv
// -----------------------------------------------------------------------------
// axis_sync_fifo
// Single-clock first-word-fall-through FIFO: rd_data shows the head entry
// whenever empty=0, and rd_en pops it.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   wr_en/wr_data : push; accepted when not full, or when full with a
//                   simultaneous pop (the pop frees the slot)
//   rd_en/rd_data : pop / head entry
//   full, empty   : status
// FIFO_DEPTH must be a power of two; pointers carry one extra wrap bit so
// full and empty are distinguishable when the indices match.
// -----------------------------------------------------------------------------
module axis_sync_fifo
   import vga_axis_pkg::*;
#(
   parameter int DATA_W     = 10,
   parameter int FIFO_DEPTH = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic              empty
);

   localparam int AW = clog2(FIFO_DEPTH);

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW:0]       wr_ptr_q;
   logic [AW:0]       rd_ptr_q;
   logic              do_wr;
   logic              do_rd;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rd_data = mem[rd_ptr_q[AW-1:0]];

   assign do_rd = rd_en && !empty;
   assign do_wr = wr_en && (!full || do_rd);

   // NOTE: storage has no reset; only the pointers define what is valid,
   // which keeps the array mappable to plain RAM.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr_q[AW-1:0]] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

endmodule

// File: rtl/vga2axis_stream.sv
// -----------------------------------------------------------------------------
// vga2axis_stream
// Converts a DE/VSYNC parallel pixel bus into AXI4-Stream video. TUSER marks
// the first pixel of a frame, TLAST the last pixel of a line. Downstream
// backpressure is absorbed by an output FIFO; on overflow the rest of the
// frame is dropped (input is never stalled) and OVERFLOW is raised.
// Ports:
//   ACLK, ARESTN   : clock, asynchronous active-low reset
//   VSYNC_IN       : 1 = vertical blanking
//   DE_IN/PIXEL_IN : active-video qualifier and pixel
//   axis           : AXI4-Stream master (TDATA/TVALID/TREADY/TUSER/TLAST/TSTRB)
//   OVF_CLR        : clears the sticky flags (a coincident set wins)
//   OVERFLOW       : sticky, a pixel was dropped because the FIFO was full
//   LINE_ERR       : sticky, a line length differed from H_ACTIVE
// Build option: define LINE_CHECK_EN to include the line-length checker;
// without it LINE_ERR is tied low and H_ACTIVE only takes part in the
// parameter sanity check.
// -----------------------------------------------------------------------------
module vga2axis_stream
   import vga_axis_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int H_ACTIVE   = 640
) (
   input  logic              ACLK,
   input  logic              ARESTN,
   input  logic              VSYNC_IN,
   input  logic              DE_IN,
   input  logic [DATA_W-1:0] PIXEL_IN,
   vga2axis_stream_if.master axis,
   input  logic              OVF_CLR,
   output logic              OVERFLOW,
   output logic              LINE_ERR
);

   localparam int ENTRY_W = DATA_W + ENTRY_FLAG_W;

   if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || H_ACTIVE < 1)
   begin : g_cfg_check
      $error("vga2axis_stream: FIFO_DEPTH must be a power of two >= 4 and H_ACTIVE >= 1");
   end

   state_t            state_q, state_d;
   logic              hold_valid_q;
   logic              hold_sof_q;
   logic [DATA_W-1:0] hold_data_q;
   logic              overflow_q;

   logic              accept;
   logic              push;
   logic              push_last;
   logic              can_write;
   logic              fifo_wr;
   logic              fifo_rd;
   logic              fifo_full;
   logic              fifo_empty;
   logic              drop;
   entry_flags_t      wr_flags;
   entry_flags_t      rd_flags;
   logic [ENTRY_W-1:0] rd_entry;

   // A pixel is taken into the hold register only while a frame is being
   // captured; VSYNC_IN high is blanking even if DE_IN is asserted.
   assign accept = DE_IN && !VSYNC_IN && (state_q == ARM || state_q == ACTIVE);

   // The hold register is a one-cycle lookahead: a held pixel is always pushed
   // on the next cycle, flagged last unless another pixel follows it directly.
   assign push      = hold_valid_q;
   assign push_last = !accept;

   // When full, a push still fits if the sink pops in the same cycle.
   assign fifo_rd   = !fifo_empty && axis.TREADY;
   assign can_write = !fifo_full || axis.TREADY;
   assign fifo_wr   = push && can_write;
   assign drop      = push && !can_write;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of block ordering.
   always_ff @(posedge ACLK or negedge ARESTN) begin
      if (!ARESTN) state_q <= SYNC;
      else         state_q <= state_d;
   end

   // NOTE: state_d gets its default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         SYNC:    if (VSYNC_IN) state_d = ARM;
         ARM:     if (accept)   state_d = ACTIVE;
         ACTIVE: begin
            if (VSYNC_IN)  state_d = ARM;   // a new frame takes priority
            else if (drop) state_d = DROP;
         end
         DROP:    if (VSYNC_IN) state_d = ARM;
         default:               state_d = SYNC;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESTN) begin
      if (!ARESTN) begin
         hold_valid_q <= 1'b0;
         hold_sof_q   <= 1'b0;
         hold_data_q  <= '0;
      end else begin
         hold_valid_q <= accept && !drop;
         if (accept) begin
            hold_data_q <= PIXEL_IN;
            hold_sof_q  <= (state_q == ARM);
         end
      end
   end

   always_ff @(posedge ACLK or negedge ARESTN) begin
      if (!ARESTN)      overflow_q <= 1'b0;
      else if (drop)    overflow_q <= 1'b1;
      else if (OVF_CLR) overflow_q <= 1'b0;
   end

   assign OVERFLOW = overflow_q;

   assign wr_flags.sof  = hold_sof_q;
   assign wr_flags.last = push_last;

   axis_sync_fifo #(
      .DATA_W     (ENTRY_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (ACLK),
      .rst_n   (ARESTN),
      .wr_en   (fifo_wr),
      .wr_data ({wr_flags, hold_data_q}),
      .rd_en   (fifo_rd),
      .rd_data (rd_entry),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // The FWFT head cannot change until it is popped, so the beat stays
   // stable for as long as the sink stalls.
   assign {rd_flags, axis.TDATA} = rd_entry;
   assign axis.TVALID = !fifo_empty;
   assign axis.TUSER  = rd_flags.sof;
   assign axis.TLAST  = rd_flags.last;
   assign axis.TSTRB  = 1'b1;

`ifdef LINE_CHECK_EN
   // Counts pixels already written for the current line; wide enough that a
   // saturated count can never alias H_ACTIVE-1.
   localparam int CNT_W = clog2(H_ACTIVE + 1) + 1;

   logic [CNT_W-1:0] line_cnt_q;
   logic             line_err_q;
   logic             len_bad;

   // Checked when the end-of-line pixel is actually written; this pixel makes
   // the line line_cnt_q+1 long.
   assign len_bad = fifo_wr && push_last && (line_cnt_q != CNT_W'(H_ACTIVE - 1));

   always_ff @(posedge ACLK or negedge ARESTN) begin
      if (!ARESTN) begin
         line_cnt_q <= '0;
         line_err_q <= 1'b0;
      end else begin
         if (state_q != ACTIVE) line_cnt_q <= '0;
         else if (fifo_wr)      line_cnt_q <= push_last ? '0 :
                                              (&line_cnt_q ? line_cnt_q : line_cnt_q + 1'b1);
         if (len_bad)      line_err_q <= 1'b1;
         else if (OVF_CLR) line_err_q <= 1'b0;
      end
   end

   assign LINE_ERR = line_err_q;
`else
   assign LINE_ERR = 1'b0;
`endif

endmodule
